// File: rtl/bus_cdc_arbiter.sv
// Round-robin arbiter that lets several bus masters share one bus_cdc port.
// Each transaction runs ISSUE, a busy-qualified WAIT with timeout, then a one-cycle response.
package cpu_reg_package;
    localparam int unsigned address_width = 32;
    localparam int unsigned data_width    = 32;

    typedef struct packed {
        logic                     we;
        logic [3:0]               we_ram;
        logic [address_width-1:0] address;
        logic [data_width-1:0]    data;
    } bus_req_t;
endpackage

module bus_cdc_arbiter
    import cpu_reg_package::*;
#(
    parameter int unsigned NumRequesters = 2,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                                         clk_i,
    input  logic                                         reset_n_i,
    input  logic [NumRequesters-1:0]                     req_valid_i,
    input  logic [NumRequesters-1:0]                     req_we_i,
    input  logic [NumRequesters-1:0][3:0]                req_we_ram_i,
    input  logic [NumRequesters-1:0][address_width-1:0] req_address_i,
    input  logic [NumRequesters-1:0][data_width-1:0]    req_data_i,
    output logic [NumRequesters-1:0]                     req_ready_o,
    output logic [NumRequesters-1:0]                     rsp_valid_o,
    output logic [data_width-1:0]                        rsp_data_o,
    output logic                                         rsp_error_o,
    output logic                                         bus_we_o,
    output logic [3:0]                                   bus_we_ram_o,
    output logic [address_width-1:0]                     bus_address_o,
    output logic [data_width-1:0]                        bus_data_o,
    input  logic [data_width-1:0]                        bus_data_i,
    input  logic                                         bus_busy_i,
    output logic [NumRequesters-1:0]                     grant_o
);
    localparam int unsigned IdxW = $clog2(NumRequesters);
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
    localparam logic [NumRequesters-1:0] OneLsb = NumRequesters'(1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t          state_q;
    logic [IdxW-1:0] rr_ptr_q;
    logic [IdxW-1:0] grant_idx_q;
    logic [CntW-1:0] wait_cnt_q;
    bus_req_t        bus_q;

    logic            pick_found_c;
    logic [IdxW-1:0] pick_idx_c;

    // First pending requester at or after rr_ptr, wrapping around.
    always_comb begin
        int unsigned idx;
        pick_found_c = 1'b0;
        pick_idx_c   = '0;
        idx          = 0;
        for (int unsigned i = 0; i < NumRequesters; i++) begin
            idx = 32'(rr_ptr_q) + i;
            if (idx >= NumRequesters) idx = idx - NumRequesters;
            if (!pick_found_c && req_valid_i[IdxW'(idx)]) begin
                pick_found_c = 1'b1;
                pick_idx_c   = IdxW'(idx);
            end
        end
    end

    // Bus master outputs come straight from the latched request register.
    assign bus_we_o      = bus_q.we;
    assign bus_we_ram_o  = bus_q.we_ram;
    assign bus_address_o = bus_q.address;
    assign bus_data_o    = bus_q.data;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            wait_cnt_q  <= '0;
            bus_q       <= '0;
            req_ready_o <= '0;
            rsp_valid_o <= '0;
            rsp_data_o  <= '0;
            rsp_error_o <= 1'b0;
            grant_o     <= '0;
        end else begin
            req_ready_o <= '0;
            rsp_valid_o <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (pick_found_c) begin
                        grant_idx_q <= pick_idx_c;
                        grant_o     <= OneLsb << pick_idx_c;
                        req_ready_o <= OneLsb << pick_idx_c;
                        bus_q       <= '{we:      req_we_i[pick_idx_c],
                                         we_ram:  req_we_ram_i[pick_idx_c],
                                         address: req_address_i[pick_idx_c],
                                         data:    req_data_i[pick_idx_c]};
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    bus_q.we     <= 1'b0;
                    bus_q.we_ram <= '0;
                    wait_cnt_q   <= '0;
                    state_q      <= S_WAIT;
                end
                S_WAIT: begin
                    // Two WAIT cycles minimum so the registered busy rise is seen.
                    if (!bus_busy_i && wait_cnt_q != '0) begin
                        rsp_valid_o <= grant_o;
                        rsp_data_o  <= bus_data_i;
                        rsp_error_o <= 1'b0;
                        grant_o     <= '0;
                        bus_q       <= '0;
                        state_q     <= S_RESP;
                    end else if (wait_cnt_q == CntW'(TimeoutCycles - 1)) begin
                        rsp_valid_o <= grant_o;
                        rsp_data_o  <= '0;
                        rsp_error_o <= 1'b1;
                        grant_o     <= '0;
                        bus_q       <= '0;
                        state_q     <= S_RESP;
                    end else if (wait_cnt_q != '1) begin
                        wait_cnt_q <= wait_cnt_q + CntW'(1);
                    end
                end
                S_RESP: begin
                    rr_ptr_q    <= (grant_idx_q == IdxW'(NumRequesters - 1)) ?
                                   '0 : grant_idx_q + IdxW'(1);
                    rsp_data_o  <= '0;
                    rsp_error_o <= 1'b0;
                    wait_cnt_q  <= '0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_cdc_arbiter.sv
// Randomized bench for bus_cdc_arbiter: a transaction-level model predicts every
// output cycle by cycle from the pending requests and the busy profile it drives.
module tb_bus_cdc_arbiter;
    import cpu_reg_package::*;

    localparam int unsigned N          = 3;
    localparam int unsigned T          = 8;
    localparam int          NCyc       = 3000;
    localparam int          ContCycles = 40;

    logic                             clk_i = 1'b0;
    logic                             reset_n_i;
    logic [N-1:0]                     req_valid_i;
    logic [N-1:0]                     req_we_i;
    logic [N-1:0][3:0]                req_we_ram_i;
    logic [N-1:0][address_width-1:0] req_address_i;
    logic [N-1:0][data_width-1:0]    req_data_i;
    logic [N-1:0]                     req_ready_o;
    logic [N-1:0]                     rsp_valid_o;
    logic [data_width-1:0]            rsp_data_o;
    logic                             rsp_error_o;
    logic                             bus_we_o;
    logic [3:0]                       bus_we_ram_o;
    logic [address_width-1:0]         bus_address_o;
    logic [data_width-1:0]            bus_data_o;
    logic [data_width-1:0]            bus_data_i;
    logic                             bus_busy_i;
    logic [N-1:0]                     grant_o;

    bus_cdc_arbiter #(.NumRequesters(N), .TimeoutCycles(T)) dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .req_valid_i   (req_valid_i),
        .req_we_i      (req_we_i),
        .req_we_ram_i  (req_we_ram_i),
        .req_address_i (req_address_i),
        .req_data_i    (req_data_i),
        .req_ready_o   (req_ready_o),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_data_o    (rsp_data_o),
        .rsp_error_o   (rsp_error_o),
        .bus_we_o      (bus_we_o),
        .bus_we_ram_o  (bus_we_ram_o),
        .bus_address_o (bus_address_o),
        .bus_data_o    (bus_data_o),
        .bus_data_i    (bus_data_i),
        .bus_busy_i    (bus_busy_i),
        .grant_o       (grant_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"},    64'(grant_o),       64'(0));
        chk({tag, "_ready"},    64'(req_ready_o),   64'(0));
        chk({tag, "_rspv"},     64'(rsp_valid_o),   64'(0));
        chk({tag, "_rsperr"},   64'(rsp_error_o),   64'(0));
        chk({tag, "_rspdata"},  64'(rsp_data_o),    64'(0));
        chk({tag, "_we"},       64'(bus_we_o),      64'(0));
        chk({tag, "_weram"},    64'(bus_we_ram_o),  64'(0));
        chk({tag, "_addr"},     64'(bus_address_o), 64'(0));
        chk({tag, "_wdata"},    64'(bus_data_o),    64'(0));
    endtask

    function automatic logic [N-1:0] oh(input int i);
        return N'(1) << i;
    endfunction

    // Transaction model: t counts cycles since ISSUE (t==0); WAIT is 1..n_wait, RESP n_wait+1.
    int                       m_ptr = 0;
    bit                       in_tx = 1'b0;
    bit                       after_rst = 1'b0;
    int                       t, w, n_wait, busy_len;
    logic                     exp_err, exp_we;
    logic [3:0]               exp_we_ram;
    logic [address_width-1:0] exp_addr;
    logic [data_width-1:0]    exp_wdata, exp_rdata;
    int                       n_done = 0, n_to = 0, n_rst = 0;
    int                       obs_q[$];

    initial begin
        reset_n_i     = 1'b0;
        req_valid_i   = '0;
        req_we_i      = '0;
        req_we_ram_i  = '0;
        req_address_i = '0;
        req_data_i    = '0;
        bus_data_i    = '0;
        bus_busy_i    = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk_all_zero("reset");

        for (int cyc = 0; cyc < NCyc; cyc++) begin
            bit           cont, rst_now, wait_now, resp_now;
            logic [N-1:0] e_grant;
            cont     = (cyc < ContCycles);
            wait_now = in_tx && t >= 1 && t <= n_wait;
            resp_now = in_tx && t == n_wait + 1;

            // Compare this cycle's outputs with the model.
            if (after_rst) chk_all_zero("post_rst");
            e_grant = (in_tx && t <= n_wait) ? oh(w) : '0;
            chk("grant", 64'(grant_o),     64'(e_grant));
            chk("ready", 64'(req_ready_o), 64'((in_tx && t == 0) ? oh(w) : '0));
            chk("rspv",  64'(rsp_valid_o), 64'(resp_now ? oh(w) : '0));
            if (resp_now) begin
                chk("rsp_err",  64'(rsp_error_o), 64'(exp_err));
                chk("rsp_data", 64'(rsp_data_o),  64'(exp_rdata));
            end
            chk("bus_we",    64'(bus_we_o),      64'((in_tx && t == 0) ? exp_we : 1'b0));
            chk("bus_weram", 64'(bus_we_ram_o),  64'((in_tx && t == 0) ? exp_we_ram : 4'h0));
            chk("bus_addr",  64'(bus_address_o), 64'((in_tx && t <= n_wait) ? exp_addr : '0));
            chk("bus_wdata", 64'(bus_data_o),    64'((in_tx && t <= n_wait) ? exp_wdata : '0));
            for (int i = 0; i < N; i++) if (req_ready_o[i]) obs_q.push_back(i);

            // Requester behaviour.
            if (in_tx && t == 0 && !cont) req_valid_i[w] = 1'b0;
            if (cont) begin
                req_valid_i      = 3'b011;
                req_we_i[0]      = 1'b0;  req_we_ram_i[0] = 4'h0;
                req_address_i[0] = 32'h0000_9000;  req_data_i[0] = 32'h0;
                req_we_i[1]      = 1'b1;  req_we_ram_i[1] = 4'hF;
                req_address_i[1] = 32'h0000_9100;  req_data_i[1] = 32'h1234_5678;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (!req_valid_i[i] && $urandom_range(0, 3) == 0) begin
                        req_valid_i[i]   = 1'b1;
                        req_we_i[i]      = 1'($urandom);
                        req_we_ram_i[i]  = 4'($urandom);
                        req_address_i[i] = ($urandom & 32'hFFFF_FFFC) | 32'h4;
                        req_data_i[i]    = $urandom;
                    end else if (req_valid_i[i] && $urandom_range(0, 19) == 0) begin
                        req_valid_i[i] = 1'b0;
                    end
                end
            end

            // Slave side: busy profile for WAIT cycles, don't-care elsewhere.
            bus_busy_i = wait_now ? (t <= busy_len) : 1'($urandom);
            bus_data_i = cont ? 32'hDEAD_BEEF : $urandom;
            if (in_tx && t == n_wait && !exp_err) exp_rdata = bus_data_i;

            rst_now   = !cont && wait_now && $urandom_range(0, 39) == 0;
            reset_n_i = !rst_now;

            // Advance the model to the next cycle.
            after_rst = rst_now;
            if (rst_now) begin
                in_tx = 1'b0;
                m_ptr = 0;
                n_rst++;
            end else if (in_tx) begin
                if (t == n_wait + 1) begin
                    in_tx = 1'b0;
                    m_ptr = (w + 1) % N;
                    n_done++;
                    if (exp_err) n_to++;
                end else begin
                    t++;
                end
            end else if (req_valid_i != '0) begin
                w = -1;
                for (int k = 0; k < N; k++)
                    if (w < 0 && req_valid_i[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                in_tx      = 1'b1;
                t          = 0;
                exp_we     = req_we_i[w];
                exp_we_ram = req_we_ram_i[w];
                exp_addr   = req_address_i[w];
                exp_wdata  = req_data_i[w];
                busy_len   = cont ? 5 : ($urandom_range(0, 3) == 0 ? 50 : int'($urandom_range(0, 9)));
                if (busy_len + 1 <= T) begin
                    n_wait  = (busy_len + 1 < 2) ? 2 : busy_len + 1;
                    exp_err = 1'b0;
                end else begin
                    n_wait    = T;
                    exp_err   = 1'b1;
                    exp_rdata = '0;
                end
            end
            @(negedge clk_i);
        end

        begin
            int exp_order [4] = '{0, 1, 0, 1};
            for (int k = 0; k < 4; k++)
                chk("cont_order", 64'(k < obs_q.size() ? obs_q[k] : -1), 64'(exp_order[k]));
        end
        chk("progress",      64'(n_done >= 100), 64'(1));
        chk("timeouts_seen", 64'(n_to > 0),      64'(1));
        chk("resets_seen",   64'(n_rst > 0),     64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
